dtcm_ctrl: RTL and testbench
============================

# dtcm_ctrl

Data tightly-coupled memory (DTCM) controller that sits directly downstream of the LSU control unit, on the LSU-to-DTCM command/response interface. It owns a word-organised SRAM array with byte write masks and returns one response per accepted command, exactly one cycle later. A one-deep registered response stage handles backpressure. After reset, an initialisation sweep clears the whole array before any command is accepted.

## Interface
- `AW`, default `` `DTCM_ADDR_WIDTH ``: byte address width.
- `DW`, default `` `XLEN `` (32): data width. `DW/8` byte lanes.
- `DEPTH`, default 1024: number of words in the array. Must be ≤ 2^(AW-2).
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `dtcm_cmd_valid`  in  1: command valid.
- `dtcm_cmd_ready`  out  1: controller can accept a command this cycle.
- `dtcm_cmd_read`  in  1: 1 = load, 0 = store.
- `dtcm_cmd_addr`  in  AW: byte address. Bits [1:0] are ignored; word index = addr[AW-1:2].
- `dtcm_cmd_wdata`  in  DW: store data.
- `dtcm_cmd_wmask`  in  DW/8: per-byte write enable for stores.
- `dtcm_rsp_valid`  out  1: response valid.
- `dtcm_rsp_ready`  in  1: consumer accepts the response.
- `dtcm_rsp_rdata`  out  DW: load data. 0 for stores and for errors.
- `dtcm_rsp_err`  out  1: the command's word index was ≥ DEPTH.
- `init_done`  out  1: initialisation sweep complete.

## Operation
- FSM states: INIT, RUN.
  - Reset enters INIT and clears the init counter `icnt`.
  - In INIT, word `icnt` is written to 0 each cycle and `icnt` increments.
  - When `icnt == DEPTH-1` is written, the FSM moves to RUN. INIT therefore lasts exactly DEPTH cycles.
  - RUN is held until the next reset.
- Command handshake: a command is accepted when `dtcm_cmd_valid & dtcm_cmd_ready`.
- `dtcm_cmd_ready = RUN & (!dtcm_rsp_valid | dtcm_rsp_ready)`. This is a combinational path from `dtcm_rsp_ready`.
- Accepted load, in range: the array is read and the data is registered into the response stage.
- Accepted store, in range: each byte lane with its `wmask` bit set is written. Lanes with the bit clear keep their old value. `rdata` = 0.
- Accepted command, out of range (index ≥ DEPTH):
  - The array is not modified.
  - Response has `err` = 1 and `rdata` = 0.
- A store with `wmask` = 0 is legal. It is a no-op write that still produces a response.
- Response stage (valid, rdata, err):
  - Loaded on every accept.
  - Cleared when the response handshakes and no new command is accepted in the same cycle.
  - Holds all fields stable while `valid & !ready`.
- Ordering:
  - Responses are returned in command order.
  - One command is in flight at most.
  - Back-to-back accept is allowed when `rsp_ready` = 1 (full throughput).
- Read-after-write: a store accepted in cycle N followed by a load to the same word accepted in N+1 returns the new data.
- Commands presented during INIT are not accepted (`ready` = 0). They are not lost: the producer holds `valid`.
- Reset mid-operation:
  - The pending response is dropped and `valid` goes to 0.
  - The FSM returns to INIT and the array is cleared again.

## Timing
- Reset values: `dtcm_rsp_valid` = 0, `dtcm_rsp_rdata` = 0, `dtcm_rsp_err` = 0, `dtcm_cmd_ready` = 0, `init_done` = 0, `icnt` = 0.
- `init_done` rises in the cycle after the last INIT write. This is reset-deassert cycle + DEPTH. `cmd_ready` can be 1 in that same cycle.
- Latency: command accepted in cycle N gives `rsp_valid` = 1 in cycle N+1.
- Backpressure: with `rsp_ready` held 0, `rsp_valid` stays 1 with stable data and `cmd_ready` stays 0.
- Simultaneous response handshake and new accept in the same cycle: the stage reloads with the new response and `valid` stays 1.
- There are no combinational paths from `cmd_*` inputs to `rsp_*` outputs.

## Test plan
- Init sweep: use DEPTH = 16 and release `rst`.
  - `cmd_ready` = 0 for cycles 0–15 and `init_done` = 1 at cycle 16.
  - Loads of all 16 words then return 0.
- Byte mask: store 0xAABBCCDD to addr 0x8 with mask 0xF, then store 0x11223344 with mask 0x5, then load 0x8.
  - The load returns 0xAA22CC44 with `err` = 0.
- Back-to-back with `rsp_ready` = 1:
  - Store 0xDEADBEEF to 0x4 in cycle N and load 0x4 in cycle N+1.
  - The response in N+2 has `rdata` = 0xDEADBEEF. `rsp_valid` is 1 in N+1 and N+2.
- Backpressure:
  - Load 0x4 with `rsp_ready` = 0 for 3 cycles: `rsp_valid` = 1 with stable data and `cmd_ready` = 0 throughout.
  - Then raise `rsp_ready` with a new command present: it is accepted in that same cycle.
- Out of range: with DEPTH = 16, store to addr 0x40 (index 16), then load 0x40.
  - Both responses have `err` = 1 and `rdata` = 0.
  - Words 0–15 are unchanged.
- Reset mid-operation: assert `rst` while `rsp_valid` = 1 and `rsp_ready` = 0.
  - The next cycle has `rsp_valid` = 0 and `init_done` = 0.
  - After INIT, the previously written word reads back as 0.

Source files
------------

// File: rtl/dtcm_ctrl.sv
// dtcm_ctrl: data tightly-coupled memory controller.
// Word-organised SRAM with byte write masks, cleared by a sweep after reset,
// fronted by a one-deep registered response stage with backpressure.

`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif
`ifndef XLEN
`define XLEN 32
`endif

module dtcm_ctrl #(
    parameter int AW    = `DTCM_ADDR_WIDTH,
    parameter int DW    = `XLEN,
    parameter int DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dtcm_cmd_valid,
    output logic            dtcm_cmd_ready,
    input  logic            dtcm_cmd_read,
    input  logic [AW-1:0]   dtcm_cmd_addr,
    input  logic [DW-1:0]   dtcm_cmd_wdata,
    input  logic [DW/8-1:0] dtcm_cmd_wmask,
    output logic            dtcm_rsp_valid,
    input  logic            dtcm_rsp_ready,
    output logic [DW-1:0]   dtcm_rsp_rdata,
    output logic            dtcm_rsp_err,
    output logic            init_done
);

    localparam int LANES = DW / 8;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    // One extra bit so DEPTH == 2^(AW-2) is representable.
    localparam logic [AW-2:0] DEPTH_W  = (AW - 1)'(DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   icnt_q;
    logic            init_done_q;

    // Response stage. rsp_load_q marks a response that carries array data;
    // stores, errors and the idle stage all present rdata = 0.
    logic            rsp_valid_q;
    logic            rsp_err_q;
    logic            rsp_load_q;
    logic [DW-1:0]   rd_data_q;

    logic [DW-1:0]   mem_q [DEPTH];

    logic [AW-3:0]   cmd_idx;
    logic            cmd_in_range;
    logic            cmd_accept;
    logic            in_init;

    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [DW-1:0]   wr_data;
    logic [LANES-1:0] wr_be;
    logic            rd_en;

    // The two byte-offset bits carry no meaning for word accesses.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^dtcm_cmd_addr[1:0];

    assign cmd_idx      = dtcm_cmd_addr[AW-1:2];
    assign cmd_in_range = ({1'b0, cmd_idx} < DEPTH_W);
    assign in_init      = (state_q == ST_INIT);

    // Ready is gated by rst so nothing slips in during the reset cycle.
    assign dtcm_cmd_ready = !rst && (state_q == ST_RUN) && (!rsp_valid_q || dtcm_rsp_ready);
    assign cmd_accept     = dtcm_cmd_valid && dtcm_cmd_ready;

    // Array port selection: the init sweep owns the write port until RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = cmd_idx[IW-1:0];
        wr_data = dtcm_cmd_wdata;
        wr_be   = dtcm_cmd_wmask;
        rd_en   = 1'b0;
        if (in_init && !rst) begin
            wr_en   = 1'b1;
            wr_idx  = icnt_q;
            wr_data = '0;
            wr_be   = '1;
        end else if (cmd_accept && cmd_in_range) begin
            wr_en = !dtcm_cmd_read;
            rd_en = dtcm_cmd_read;
        end
    end

    // Byte-masked write port and registered read port of the array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < LANES; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem_q[cmd_idx[IW-1:0]];
        end
    end

    // INIT/RUN sequencer: one word cleared per cycle, then RUN until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            icnt_q      <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    icnt_q <= icnt_q + 1'b1;
                    if (icnt_q == LAST_IDX) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_RUN;
                    init_done_q <= 1'b1;
                end
            endcase
        end
    end

    // Response stage: load on accept, clear on drain, hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else if (cmd_accept) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !cmd_in_range;
            rsp_load_q  <= dtcm_cmd_read && cmd_in_range;
        end else if (dtcm_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
        end
    end

    assign dtcm_rsp_valid = rsp_valid_q;
    assign dtcm_rsp_err   = rsp_err_q;
    assign dtcm_rsp_rdata = rsp_load_q ? rd_data_q : '0;
    assign init_done      = init_done_q;

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Testbench for dtcm_ctrl (DEPTH = 16): table-driven command vectors with a
// response scoreboard, plus hand sequences for init, back-to-back,
// backpressure and mid-operation reset.
module tb_dtcm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int tests_run = 0;
    int n_fail    = 0;
    int n_rsp     = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 40;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    dtcm_ctrl #(.AW(16), .DW(32), .DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .dtcm_cmd_valid (cmd_valid),
        .dtcm_cmd_ready (cmd_ready),
        .dtcm_cmd_read  (cmd_read),
        .dtcm_cmd_addr  (cmd_addr),
        .dtcm_cmd_wdata (cmd_wdata),
        .dtcm_cmd_wmask (cmd_wmask),
        .dtcm_rsp_valid (rsp_valid),
        .dtcm_rsp_ready (rsp_ready),
        .dtcm_rsp_rdata (rsp_rdata),
        .dtcm_rsp_err   (rsp_err),
        .init_done      (init_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic [15:0] a, input logic [31:0] wd,
                                input logic [3:0] wm, input logic [31:0] er, input logic ee);
        vec_t v;
        v.rd = rd; v.addr = a; v.wdata = wd; v.wmask = wm; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic push_exp(input logic [31:0] r, input logic e);
        exp_t x;
        x.rdata = r;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    // Present one command, wait (bounded) for acceptance, record expectation.
    task automatic send(input vec_t v);
        int k;
        cmd_valid = 1'b1;
        cmd_read  = v.rd;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_wmask = v.wmask;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            tests_run++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: addr %h never accepted", v.addr);
        end else begin
            push_exp(v.exp_rdata, v.exp_err);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Scoreboard: a response is consumed at the edge after valid & ready.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            exp_t x;
            n_rsp++;
            if (exp_q.size() == 0) begin
                tests_run++;
                n_fail++;
                $display("[TB] FAIL sb_underflow: unexpected rsp rdata=%h err=%0d", rsp_rdata, rsp_err);
            end else begin
                x = exp_q.pop_front();
                $display("[TB] rsp %0d: rdata=%h err=%0d (want %h/%0d)", n_rsp, rsp_rdata, rsp_err, x.rdata, x.err);
                check("sb_rdata", rsp_rdata, x.rdata);
                check("sb_err", {31'b0, rsp_err}, {31'b0, x.err});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;

        // Vector table.
        n = 0;
        for (int i = 0; i < 16; i++) begin
            vecs[n] = mk(1'b1, 16'(i * 4), 32'h0, 4'h0, 32'h0, 1'b0); n++;
        end
        vecs[n] = mk(1'b0, 16'h0008, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0); n++;
        vecs[n] = mk(1'b0, 16'h0008, 32'h11223344, 4'h5, 32'h0, 1'b0); n++;
        vecs[n] = mk(1'b1, 16'h0008, 32'h0, 4'h0, 32'hAA22CC44, 1'b0); n++;
        vecs[n] = mk(1'b0, 16'h0008, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0); n++;
        vecs[n] = mk(1'b1, 16'h000B, 32'h0, 4'h0, 32'hAA22CC44, 1'b0); n++;
        vecs[n] = mk(1'b0, 16'h0040, 32'h55555555, 4'hF, 32'h0, 1'b1); n++;
        vecs[n] = mk(1'b1, 16'h0040, 32'h0, 4'h0, 32'h0, 1'b1); n++;
        vecs[n] = mk(1'b1, 16'hFFFC, 32'h0, 4'h0, 32'h0, 1'b1); n++;
        for (int i = 0; i < 16; i++) begin
            vecs[n] = mk(1'b1, 16'(i * 4), 32'h0, 4'h0, (i == 2) ? 32'hAA22CC44 : 32'h0, 1'b0); n++;
        end

        rst = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        check("rst_init_done", {31'b0, init_done}, 32'h0);

        // Init sweep: 16 cycles not ready, init_done in cycle 16.
        @(posedge clk); #1; rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check("init_cmd_ready", {31'b0, cmd_ready}, 32'h0);
            check("init_done_low", {31'b0, init_done}, 32'h0);
        end
        @(negedge clk);
        check("init_done_high", {31'b0, init_done}, 32'h1);
        check("run_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        @(posedge clk); #1;

        // Table-driven vectors.
        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i]);
        end

        // Back-to-back store then load of the same word.
        cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 16'h0004;
        cmd_wdata = 32'hDEADBEEF; cmd_wmask = 4'hF;
        @(negedge clk);
        check("b2b_ready_n", {31'b0, cmd_ready}, 32'h1);
        push_exp(32'h0, 1'b0);
        @(posedge clk); #1;
        cmd_read = 1'b1; cmd_wdata = 32'h0; cmd_wmask = 4'h0;
        @(negedge clk);
        check("b2b_valid_n1", {31'b0, rsp_valid}, 32'h1);
        check("b2b_ready_n1", {31'b0, cmd_ready}, 32'h1);
        push_exp(32'hDEADBEEF, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid_n2", {31'b0, rsp_valid}, 32'h1);
        check("b2b_rdata_n2", rsp_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Backpressure: hold a load response, keep a second command waiting.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 16'h0004;
        @(negedge clk);
        check("bp_first_ready", {31'b0, cmd_ready}, 32'h1);
        push_exp(32'hDEADBEEF, 1'b0);
        @(posedge clk); #1;
        cmd_addr = 16'h0008;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, rsp_valid}, 32'h1);
            check("bp_rdata", rsp_rdata, 32'hDEADBEEF);
            check("bp_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'b0, cmd_ready}, 32'h1);
        push_exp(32'hAA22CC44, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_reload_valid", {31'b0, rsp_valid}, 32'h1);
        check("bp_reload_rdata", rsp_rdata, 32'hAA22CC44);
        @(posedge clk); #1;

        // Reset mid-operation with a response pending.
        send(mk(1'b0, 16'h000C, 32'h12345678, 4'hF, 32'h0, 1'b0));
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 16'h000C;
        @(negedge clk);
        check("mr_accept_ready", {31'b0, cmd_ready}, 32'h1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mr_pending_valid", {31'b0, rsp_valid}, 32'h1);
        check("mr_pending_rdata", rsp_rdata, 32'h12345678);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mr_valid_dropped", {31'b0, rsp_valid}, 32'h0);
        check("mr_init_done_low", {31'b0, init_done}, 32'h0);
        check("mr_cmd_ready_low", {31'b0, cmd_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (!init_done && k < 40) begin
            k++;
            @(negedge clk);
        end
        check("mr_reinit_done", {31'b0, init_done}, 32'h1);
        @(posedge clk); #1;
        send(mk(1'b1, 16'h000C, 32'h0, 4'h0, 32'h0, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
        $finish;
    end

endmodule
